// File: rtl/cbs_tile_scheduler.sv
// CBS tile scheduler: walks one conv->BN->SiLU layer over filter groups (outer loop)
// and image tiles (inner loop). It fetches each filter bank once per group and each
// image tile once per tile, pulses the engine, waits for the result under a watchdog,
// and hands each result to writeback before moving on.
module cbs_tile_scheduler #(
    parameter int TILE_CW     = 8,
    parameter int GRP_CW      = 4,
    parameter int CLEAR_CYC   = 2,
    parameter int TIMEOUT_CW  = 16,
    parameter int ENG_TIMEOUT = 10000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [TILE_CW-1:0] cfg_num_tiles_i,
    input  logic [GRP_CW-1:0]  cfg_num_groups_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               w_req_o,
    output logic [GRP_CW-1:0]  w_grp_idx_o,
    input  logic               w_ack_i,
    output logic               x_req_o,
    output logic [TILE_CW-1:0] x_tile_idx_o,
    input  logic               x_ack_i,
    output logic               eng_clear_o,
    output logic               eng_start_o,
    input  logic               eng_done_i,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    // Wide enough to hold CLEAR_CYC-1 even when CLEAR_CYC is 1.
    localparam int CLR_CW = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_CLEAR,
        ST_RUN,
        ST_WAIT,
        ST_DRAIN,
        ST_FIN
    } state_e;

    state_e                state_q, state_d;
    logic [TILE_CW-1:0]    num_tiles_q, num_tiles_d;
    logic [GRP_CW-1:0]     num_groups_q, num_groups_d;
    logic [TILE_CW-1:0]    tile_q, tile_d;
    logic [GRP_CW-1:0]     grp_q, grp_d;
    logic [CLR_CW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [TIMEOUT_CW-1:0] wdog_q, wdog_d;
    logic                  err_q, err_d;

    logic last_tile;
    logic last_grp;

    assign last_tile = (tile_q == num_tiles_q - TILE_CW'(1));
    assign last_grp  = (grp_q == num_groups_q - GRP_CW'(1));

    // State and datapath registers; synchronous reset aborts any layer in progress.
    // NOTE: sequential state uses non-blocking (<=) so every register samples the
    // pre-edge value of its neighbours; blocking here would create ordering races.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            num_tiles_q  <= '0;
            num_groups_q <= '0;
            tile_q       <= '0;
            grp_q        <= '0;
            clr_cnt_q    <= '0;
            wdog_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_tiles_q  <= num_tiles_d;
            num_groups_q <= num_groups_d;
            tile_q       <= tile_d;
            grp_q        <= grp_d;
            clr_cnt_q    <= clr_cnt_d;
            wdog_q       <= wdog_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic and Moore outputs decoded from the current state.
    // NOTE: every signal driven here gets a default first, so no path can leave a
    // value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        num_tiles_d  = num_tiles_q;
        num_groups_d = num_groups_q;
        tile_d       = tile_q;
        grp_d        = grp_q;
        clr_cnt_d    = clr_cnt_q;
        wdog_d       = wdog_q;
        err_d        = err_q;

        busy_o      = (state_q != ST_IDLE);
        done_o      = 1'b0;
        w_req_o     = 1'b0;
        x_req_o     = 1'b0;
        eng_clear_o = 1'b0;
        eng_start_o = 1'b0;
        out_valid_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                eng_clear_o = 1'b1;
                if (start_i) begin
                    num_tiles_d  = cfg_num_tiles_i;
                    num_groups_d = cfg_num_groups_i;
                    err_d        = 1'b0;
                    tile_d       = '0;
                    grp_d        = '0;
                    // An empty layer still produces a done pulse, just with no work.
                    if (cfg_num_tiles_i == '0 || cfg_num_groups_i == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD_W;
                    end
                end
            end

            ST_LOAD_W: begin
                w_req_o = 1'b1;
                if (w_ack_i) begin
                    state_d = ST_LOAD_X;
                end
            end

            ST_LOAD_X: begin
                x_req_o = 1'b1;
                if (x_ack_i) begin
                    clr_cnt_d = '0;
                    state_d   = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                eng_clear_o = 1'b1;
                if (clr_cnt_q == CLR_CW'(CLEAR_CYC - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_CW'(1);
                end
            end

            ST_RUN: begin
                eng_start_o = 1'b1;
                wdog_d      = '0;
                state_d     = ST_WAIT;
            end

            ST_WAIT: begin
                // A result arriving on the final watchdog cycle still counts.
                if (eng_done_i) begin
                    state_d = ST_DRAIN;
                end else if (wdog_q == TIMEOUT_CW'(ENG_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_CW'(1);
                end
            end

            ST_DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (!last_tile) begin
                        tile_d  = tile_q + TILE_CW'(1);
                        state_d = ST_LOAD_X;
                    end else begin
                        tile_d = '0;
                        if (!last_grp) begin
                            grp_d   = grp_q + GRP_CW'(1);
                            state_d = ST_LOAD_W;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end
                end
            end

            ST_FIN: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err_o        = err_q;
    assign w_grp_idx_o  = grp_q;
    assign x_tile_idx_o = tile_q;

endmodule

// File: tb/tb_cbs_tile_scheduler.sv
// Directed bench for cbs_tile_scheduler: layer sizes, stalls, watchdog, mid-run reset.
module tb_cbs_tile_scheduler;

    localparam int TILE_CW     = 8;
    localparam int GRP_CW      = 4;
    localparam int CLEAR_CYC   = 2;
    localparam int TIMEOUT_CW  = 16;
    localparam int ENG_TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               reset_i;
    logic               start_i;
    logic [TILE_CW-1:0] cfg_num_tiles_i;
    logic [GRP_CW-1:0]  cfg_num_groups_i;
    logic               busy_o, done_o, err_o;
    logic               w_req_o, x_req_o;
    logic [GRP_CW-1:0]  w_grp_idx_o;
    logic [TILE_CW-1:0] x_tile_idx_o;
    logic               w_ack_i, x_ack_i;
    logic               eng_clear_o, eng_start_o, eng_done_i;
    logic               out_valid_o, out_ready_i;

    int vectors     = 0;
    int miscompares = 0;

    // Event log filled by the monitor.
    logic [GRP_CW-1:0]         w_log[$];
    logic [TILE_CW-1:0]        x_log[$];
    logic [GRP_CW+TILE_CW-1:0] out_log[$];
    int                        start_cnt;
    int                        done_cnt;
    bit                        any_activity;

    always #5 clk = ~clk;

    cbs_tile_scheduler #(
        .TILE_CW    (TILE_CW),
        .GRP_CW     (GRP_CW),
        .CLEAR_CYC  (CLEAR_CYC),
        .TIMEOUT_CW (TIMEOUT_CW),
        .ENG_TIMEOUT(ENG_TIMEOUT)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .cfg_num_tiles_i (cfg_num_tiles_i),
        .cfg_num_groups_i(cfg_num_groups_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .w_req_o         (w_req_o),
        .w_grp_idx_o     (w_grp_idx_o),
        .w_ack_i         (w_ack_i),
        .x_req_o         (x_req_o),
        .x_tile_idx_o    (x_tile_idx_o),
        .x_ack_i         (x_ack_i),
        .eng_clear_o     (eng_clear_o),
        .eng_start_o     (eng_start_o),
        .eng_done_i      (eng_done_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i)
    );

    // Mid-cycle monitor: records every handshake the DUT will act on at the next edge.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (w_req_o && w_ack_i)         w_log.push_back(w_grp_idx_o);
            if (x_req_o && x_ack_i)         x_log.push_back(x_tile_idx_o);
            if (out_valid_o && out_ready_i) out_log.push_back({w_grp_idx_o, x_tile_idx_o});
            if (eng_start_o)                start_cnt++;
            if (done_o)                     done_cnt++;
            if (w_req_o || x_req_o || eng_start_o || out_valid_o) any_activity = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        w_log.delete();
        x_log.delete();
        out_log.delete();
        start_cnt    = 0;
        done_cnt     = 0;
        any_activity = 1'b0;
    endtask

    // Present start for exactly one edge; returns #1 after the accepting edge.
    task automatic start_layer(input int tiles, input int groups);
        @(posedge clk);
        #1;
        start_i          = 1'b1;
        cfg_num_tiles_i  = TILE_CW'(tiles);
        cfg_num_groups_i = GRP_CW'(groups);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done is seen (1 = first cycle).
    task automatic run_to_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_o && cyc < budget);
        chk({tag, "_done_seen"}, 32'(done_o), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        chk({tag, "_busy_dropped"}, 32'(busy_o), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},   32'(busy_o),       32'd0);
        chk({tag, "_done"},   32'(done_o),       32'd0);
        chk({tag, "_err"},    32'(err_o),        32'd0);
        chk({tag, "_wreq"},   32'(w_req_o),      32'd0);
        chk({tag, "_xreq"},   32'(x_req_o),      32'd0);
        chk({tag, "_start"},  32'(eng_start_o),  32'd0);
        chk({tag, "_valid"},  32'(out_valid_o),  32'd0);
        chk({tag, "_clear"},  32'(eng_clear_o),  32'd1);
        chk({tag, "_grp"},    32'(w_grp_idx_o),  32'd0);
        chk({tag, "_tile"},   32'(x_tile_idx_o), 32'd0);
    endtask

    // Two tiles, one group, everything answering at once: LOAD_W + 2*(1+CLEAR_CYC+3) + FIN.
    task automatic run_t1(input string tag);
        int cyc;
        clear_log();
        start_layer(2, 1);
        run_to_done(tag, 100, cyc);
        chk({tag, "_latency"},  32'(cyc),           32'd14);
        chk({tag, "_w_count"},  32'(w_log.size()),  32'd1);
        chk({tag, "_x_count"},  32'(x_log.size()),  32'd2);
        chk({tag, "_starts"},   32'(start_cnt),     32'd2);
        chk({tag, "_dones"},    32'(done_cnt),      32'd1);
        chk({tag, "_out_count"}, 32'(out_log.size()), 32'd2);
        if (out_log.size() == 2) begin
            chk({tag, "_out0"}, 32'(out_log[0]), 32'h000);
            chk({tag, "_out1"}, 32'(out_log[1]), 32'h001);
        end
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        logic [TILE_CW-1:0] held_tile;
        logic [GRP_CW-1:0]  held_grp;

        reset_i          = 1'b1;
        start_i          = 1'b0;
        cfg_num_tiles_i  = '0;
        cfg_num_groups_i = '0;
        w_ack_i          = 1'b1;
        x_ack_i          = 1'b1;
        eng_done_i       = 1'b1;
        out_ready_i      = 1'b1;
        clear_log();

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("rst");
        reset_i = 1'b0;

        // T1: 2 tiles x 1 group with immediate responses.
        run_t1("t1");

        // T2: 3 tiles x 2 groups; 2*(1 + 3*6) + FIN = 39 cycles.
        clear_log();
        start_layer(3, 2);
        run_to_done("t2", 200, cyc);
        chk("t2_latency", 32'(cyc), 32'd39);
        chk("t2_w_count", 32'(w_log.size()), 32'd2);
        chk("t2_x_count", 32'(x_log.size()), 32'd6);
        chk("t2_out_count", 32'(out_log.size()), 32'd6);
        if (w_log.size() == 2) begin
            chk("t2_w0", 32'(w_log[0]), 32'd0);
            chk("t2_w1", 32'(w_log[1]), 32'd1);
        end
        for (int i = 0; i < 6 && i < x_log.size(); i++) begin
            chk($sformatf("t2_x%0d", i), 32'(x_log[i]), 32'(i % 3));
        end
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            chk($sformatf("t2_out%0d", i), 32'(out_log[i]), 32'(((i / 3) << TILE_CW) | (i % 3)));
        end
        chk("t2_starts", 32'(start_cnt), 32'd6);

        // T3: empty layers go straight to FIN.
        clear_log();
        start_layer(0, 5);
        run_to_done("t3a", 10, cyc);
        chk("t3a_latency", 32'(cyc), 32'd1);
        chk("t3a_activity", 32'(any_activity), 32'd0);
        clear_log();
        start_layer(4, 0);
        run_to_done("t3b", 10, cyc);
        chk("t3b_latency", 32'(cyc), 32'd1);
        chk("t3b_activity", 32'(any_activity), 32'd0);

        // T4: engine never finishes; 16 WAIT cycles then FIN with err.
        eng_done_i = 1'b0;
        clear_log();
        start_layer(2, 1);
        run_to_done("t4", 100, cyc);
        chk("t4_latency", 32'(cyc), 32'd22);
        chk("t4_err_sticky", 32'(err_o), 32'd1);
        chk("t4_starts", 32'(start_cnt), 32'd1);
        chk("t4_out_count", 32'(out_log.size()), 32'd0);
        eng_done_i = 1'b1;
        clear_log();
        start_layer(1, 1);
        @(negedge clk);
        chk("t4_err_cleared", 32'(err_o), 32'd0);
        run_to_done("t4b", 100, cyc);
        chk("t4b_latency", 32'(cyc + 1), 32'd8);
        chk("t4b_err", 32'(err_o), 32'd0);

        // T5: writeback stalls for 5 cycles.
        out_ready_i = 1'b0;
        clear_log();
        start_layer(2, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_o && n < 50);
        chk("t5_valid_seen", 32'(out_valid_o), 32'd1);
        held_tile = x_tile_idx_o;
        held_grp  = w_grp_idx_o;
        chk("t5_first_tile", 32'(held_tile), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_valid_hold%0d", i), 32'(out_valid_o), 32'd1);
            chk($sformatf("t5_tile_hold%0d", i), 32'(x_tile_idx_o), 32'(held_tile));
            chk($sformatf("t5_grp_hold%0d", i), 32'(w_grp_idx_o), 32'(held_grp));
            chk($sformatf("t5_no_xreq%0d", i), 32'(x_req_o), 32'd0);
            @(negedge clk);
        end
        chk("t5_x_count_stalled", 32'(x_log.size()), 32'd1);
        out_ready_i = 1'b1;
        run_to_done("t5", 100, cyc);
        chk("t5_out_count", 32'(out_log.size()), 32'd2);
        if (out_log.size() == 2) begin
            chk("t5_out1", 32'(out_log[1]), 32'h001);
        end

        // T6: reset while the engine is running.
        eng_done_i = 1'b0;
        clear_log();
        start_layer(2, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eng_start_o && n < 50);
        chk("t6_start_seen", 32'(eng_start_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("t6_busy_in_wait", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t6_rst");
        reset_i    = 1'b0;
        eng_done_i = 1'b1;
        run_t1("t6_rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
